// File: rtl/ladybird_bus_pkg.sv
// rtl/ladybird_bus_pkg.sv - shared types and widths for the ladybird memory bus
package ladybird_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;

  typedef struct packed {
    logic                  req;
    logic [BUS_STRB_W-1:0] wstrb;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
  } bus_request_s;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ladybird_bus_rr_arbiter_if.sv
// rtl/ladybird_bus_rr_arbiter_if.sv - core-side and memory-side bus signals of the arbiter
interface ladybird_bus_rr_arbiter_if #(
  parameter int N_INPUT = 2
);
  import ladybird_bus_pkg::*;

  logic [N_INPUT-1:0]            in_req;
  logic [N_INPUT*BUS_STRB_W-1:0] in_wstrb;
  logic [N_INPUT*BUS_ADDR_W-1:0] in_addr;
  logic [N_INPUT*BUS_DATA_W-1:0] in_wdata;
  logic [N_INPUT-1:0]            in_gnt;
  logic [N_INPUT-1:0]            in_data_gnt;
  logic [BUS_DATA_W-1:0]         in_rdata;
  logic                          out_req;
  logic [BUS_STRB_W-1:0]         out_wstrb;
  logic [BUS_ADDR_W-1:0]         out_addr;
  logic [BUS_DATA_W-1:0]         out_wdata;
  logic                          out_gnt;
  logic                          out_data_gnt;
  logic [BUS_DATA_W-1:0]         out_rdata;

  modport slave (
    input  in_req, in_wstrb, in_addr, in_wdata, out_gnt, out_data_gnt, out_rdata,
    output in_gnt, in_data_gnt, in_rdata, out_req, out_wstrb, out_addr, out_wdata
  );

  modport master (
    output in_req, in_wstrb, in_addr, in_wdata, out_gnt, out_data_gnt, out_rdata,
    input  in_gnt, in_data_gnt, in_rdata, out_req, out_wstrb, out_addr, out_wdata
  );

endinterface

// File: rtl/ladybird_id_fifo.sv
// rtl/ladybird_id_fifo.sv - in-order queue of requester IDs for outstanding transactions
module ladybird_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ladybird_bus_rr_arbiter.sv
// rtl/ladybird_bus_rr_arbiter.sv - round-robin arbiter sharing one ladybird bus port between masters
module ladybird_bus_rr_arbiter
  import ladybird_bus_pkg::*;
#(
  parameter int N_INPUT         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = id_width(N_INPUT)
) (
  input  logic                           clk,
  input  logic                           anrst,
  input  logic                           nrst,
  ladybird_bus_rr_arbiter_if.slave       bus,
  output logic                           o_err
);

  bus_request_s    reqs [N_INPUT];
  bus_request_s    cur;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] first_any;
  logic [ID_W-1:0] first_hi;
  logic            hi_found;
  logic [ID_W-1:0] lock_idx;
  logic            lock_valid;
  logic [ID_W-1:0] last_idx;
  logic            any_req;
  logic            lock_dropped;
  logic            req_ok;
  logic            accept;
  logic            q_full;
  logic            q_empty;
  logic [ID_W-1:0] head_id;

  always_comb begin
    for (int i = 0; i < N_INPUT; i++) begin
      reqs[i] = '{req:   bus.in_req[i],
                  wstrb: bus.in_wstrb[i*BUS_STRB_W +: BUS_STRB_W],
                  addr:  bus.in_addr[i*BUS_ADDR_W +: BUS_ADDR_W],
                  data:  bus.in_wdata[i*BUS_DATA_W +: BUS_DATA_W]};
    end
  end

  // Lowest requester above last_idx wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    first_any = '0;
    first_hi  = '0;
    hi_found  = 1'b0;
    for (int i = N_INPUT-1; i >= 0; i--) begin
      if (bus.in_req[i]) first_any = ID_W'(i);
      if (bus.in_req[i] && (ID_W'(i) > last_idx)) begin
        first_hi = ID_W'(i);
        hi_found = 1'b1;
      end
    end
  end

  assign sel          = lock_valid ? lock_idx : (hi_found ? first_hi : first_any);
  assign cur          = reqs[sel];
  assign any_req      = |bus.in_req;
  assign lock_dropped = lock_valid && !cur.req;
  assign req_ok       = any_req && !q_full && !lock_dropped;
  assign accept       = req_ok && bus.out_gnt;

  assign bus.out_req   = req_ok;
  assign bus.out_wstrb = req_ok ? cur.wstrb : '0;
  assign bus.out_addr  = req_ok ? cur.addr  : '0;
  assign bus.out_wdata = req_ok ? cur.data  : '0;
  assign bus.in_rdata  = bus.out_rdata;

  always_comb begin
    bus.in_gnt      = '0;
    bus.in_data_gnt = '0;
    if (accept) bus.in_gnt[sel] = 1'b1;
    if (bus.out_data_gnt && !q_empty) bus.in_data_gnt[head_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      last_idx   <= ID_W'(N_INPUT-1);
      o_err      <= 1'b0;
    end else if (!nrst) begin
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      last_idx   <= ID_W'(N_INPUT-1);
      o_err      <= 1'b0;
    end else begin
      if (accept) begin
        lock_valid <= 1'b0;
        last_idx   <= sel;
      end else if (req_ok) begin
        lock_valid <= 1'b1;
        lock_idx   <= sel;
      end else if (lock_dropped) begin
        lock_valid <= 1'b0;
      end
      if (bus.out_data_gnt && q_empty) o_err <= 1'b1;
    end
  end

  ladybird_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .anrst     (anrst),
    .nrst      (nrst),
    .push      (accept),
    .push_data (sel),
    .pop       (bus.out_data_gnt),
    .head_data (head_id),
    .empty     (q_empty),
    .full      (q_full)
  );

endmodule

// File: doc/ladybird_bus_rr_arbiter.md
Name: ladybird_bus_rr_arbiter

Overview:
- N-way round-robin arbiter that shares one ladybird memory bus port between several masters (fetch, LSU, debug).
- Tracks accepted transactions in an in-order ID queue, so each out_data_gnt returns to the master that issued the request.
- Replaces fixed-priority selection where starvation matters. Sits between the core-side masters and the single memory/interconnect port.

Parameters:
- N_INPUT, 2, number of requesting masters (2..8).
- MAX_OUTSTANDING, 4, accepted-but-not-completed transactions allowed (power of 2, >=2).
- ID_W, $clog2(N_INPUT) (min 1), width of the requester ID stored per transaction.

Ports:
- clk  input  1  clock
- anrst  input  1  reset; asynchronous, active-low
- nrst  input  1  synchronous reset, active-low; same effect as anrst at the clk edge
- in_req  input  N_INPUT  per-master request
- in_wstrb  input  N_INPUT*4  per-master byte strobes; 0 = read
- in_addr  input  N_INPUT*32  per-master address
- in_wdata  input  N_INPUT*32  per-master write data
- in_gnt  output  N_INPUT  per-master request accepted
- in_data_gnt  output  N_INPUT  per-master response valid
- in_rdata  output  32  read data, broadcast to all masters
- out_req  output  1  request to memory
- out_wstrb  output  4  selected strobes
- out_addr  output  32  selected address
- out_wdata  output  32  selected write data
- out_gnt  input  1  memory accepted request
- out_data_gnt  input  1  memory response valid (one per accepted transaction, in order)
- out_rdata  input  32  memory read data
- o_err  output  1  sticky: out_data_gnt received with empty queue

Behaviour:
- Handshake: a transaction is accepted when out_req && out_gnt in the same cycle.
  - Memory completes every accepted transaction (read or write) with exactly one out_data_gnt, in acceptance order, no earlier than the cycle after acceptance.
- Selection (combinational, 0-cycle):
  - If lock_valid, sel = lock_idx.
  - Otherwise sel = first i with in_req[i], scanning from (last_idx+1) mod N_INPUT upward with wrap.
  - any_req = at least one in_req set.
- out_req = any_req && !q_full. out_wstrb, out_addr and out_wdata come from sel; they are 0 when out_req = 0.
- in_gnt[i] = (i == sel) && out_req && out_gnt. All other bits are 0.
- Lock, to keep a request stable while stalled:
  - On out_req && !out_gnt: lock_valid <= 1, lock_idx <= sel.
  - On acceptance: lock_valid <= 0.
  - A locked master that drops in_req (protocol violation) clears the lock in the next cycle. No transaction is recorded.
- Round-robin: on acceptance, last_idx <= sel. Reset value of last_idx = N_INPUT-1, so master 0 wins first.
- ID queue (depth MAX_OUTSTANDING, count 0..MAX_OUTSTANDING):
  - Push sel on acceptance. Pop on out_data_gnt.
  - q_full = (count == MAX_OUTSTANDING). While full, out_req = 0 even if a pop occurs in the same cycle; there is no full-bypass.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance. Pointers wrap modulo depth.
- Response routing (combinational):
  - in_data_gnt[head_id] = out_data_gnt when the queue is not empty. All other bits are 0.
  - in_rdata = out_rdata always.
- out_data_gnt with the queue empty: no pop, in_data_gnt all 0, o_err <= 1. o_err clears only on reset.
- Reset (anrst low, or nrst low at the edge):
  - count = 0, pointers = 0, lock_valid = 0, last_idx = N_INPUT-1, o_err = 0.
  - All outputs are then 0 apart from the combinational pass-through of out_rdata.
- Reset mid-operation discards outstanding IDs. Responses arriving after reset raise o_err.

Decomposition:
- Package ladybird_bus_pkg holds:
  - bus_request_s (req, wstrb[3:0], addr[31:0], data[31:0]);
  - constants BUS_ADDR_W = 32, BUS_DATA_W = 32, BUS_STRB_W = 4.
- Sub-module ladybird_id_fifo (params WIDTH, DEPTH):
  - ports push, push_data, pop, head_data, empty, full;
  - reset by anrst and nrst.
- The arbiter holds the selection, lock and round-robin logic.

Test Plan:
- Fairness: N_INPUT=2, both in_req held high, out_gnt=1 every cycle, out_data_gnt 1 cycle later. Required: in_gnt alternates 01,10,01,10; in_data_gnt follows the same order delayed by 1 cycle.
- Stall lock: master 1 requests alone with out_gnt=0 for 3 cycles; master 0 raises in_req in cycle 2. Required: out_addr stays master 1's address, and in_gnt = 10 when out_gnt rises. The next grant goes to master 0.
- Backpressure: MAX_OUTSTANDING=4, master 0 issues 4 reads with out_data_gnt held low. Required: out_req = 0 from cycle 5 on. A single out_data_gnt pulse leaves out_req 0 in that cycle and 1 in the next.
- Out-of-order issue order: accept the sequence M1 read A=0x100, M0 write A=0x200 wstrb=0xF, M1 read A=0x104. Return 3 out_data_gnt with out_rdata 0xAA, 0xBB, 0xCC. Required: in_data_gnt pulses M1, M0, M1 in that order, and in_rdata matches each pulse.
- Simultaneous push/pop at count=2: count remains 2, and the head ID is the next oldest.
- Error and reset: out_data_gnt with an empty queue sets o_err = 1. Asserting anrst mid-stream with 2 outstanding clears o_err, count and lock. After anrst deasserts, master 0 is granted first.
